// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM read/write port between two bus masters.
// Port 0 is the cpu core and port 1 is a secondary master such as a loader.
// Each master has a one-entry posted-write buffer. Reads are held by the
// master until rd_valid. Grants are round-robin. A port's read never
// overtakes that port's own buffered write.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   mN_rd_en / mN_rd_addr        read request, held until mN_rd_valid
//   mN_rd_data / mN_rd_valid     read result; valid is a one-cycle pulse
//   mN_wr_en / addr / data       one-cycle write strobe with its payload
//   mN_wr_busy                   write buffer full; do not strobe wr_en
//   ram_rd_en / addr / data / valid   RAM read port
//   ram_wr_en / addr / data           RAM write port (one-cycle pulse)
//   grant                        one-hot current owner, 0 when idle
//   err                          sticky: [0]/[1] write overflow, [2] read timeout
//
// Handshake semantics, in one place:
//   - Write: the master may pulse wr_en for one cycle whenever wr_busy is 0.
//     The write is accepted on that edge, and wr_busy rises on the next cycle.
//   - Read: the master raises rd_en with a stable rd_addr and holds both until
//     it sees rd_valid. The master then drops rd_en. The DONE cycle gives it
//     the time to do so before IDLE samples requests again.
//   - RAM read: ram_rd_en stays high with a stable address until ram_rd_valid
//     is seen or the timeout expires.
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_rd_en,
  input  logic [AW-1:0] m0_rd_addr,
  output logic [DW-1:0] m0_rd_data,
  output logic          m0_rd_valid,
  input  logic          m0_wr_en,
  input  logic [AW-1:0] m0_wr_addr,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_wr_busy,
  input  logic          m1_rd_en,
  input  logic [AW-1:0] m1_rd_addr,
  output logic [DW-1:0] m1_rd_data,
  output logic          m1_rd_valid,
  input  logic          m1_wr_en,
  input  logic [AW-1:0] m1_wr_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_wr_busy,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  input  logic          ram_rd_valid,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [1:0]    grant,
  output logic [2:0]    err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [8:0] TO_LIM = 9'(RD_TIMEOUT);

  // Per-port views of the master inputs, indexed by port number.
  logic [1:0]         rd_en_v, wr_en_v;
  logic [1:0][AW-1:0] rd_addr_v, wr_addr_v;
  logic [1:0][DW-1:0] wr_data_v;

  assign rd_en_v   = {m1_rd_en, m0_rd_en};
  assign wr_en_v   = {m1_wr_en, m0_wr_en};
  assign rd_addr_v = {m1_rd_addr, m0_rd_addr};
  assign wr_addr_v = {m1_wr_addr, m0_wr_addr};
  assign wr_data_v = {m1_wr_data, m0_wr_data};

  state_e             state_q, state_d;
  logic [1:0]         wbuf_valid_q, wbuf_valid_d;
  logic [1:0][AW-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [1:0][DW-1:0] wbuf_data_q, wbuf_data_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ram_rd_en_q, ram_rd_en_d;
  logic [AW-1:0]      ram_rd_addr_q, ram_rd_addr_d;
  logic               ram_wr_en_q, ram_wr_en_d;
  logic [AW-1:0]      ram_wr_addr_q, ram_wr_addr_d;
  logic [DW-1:0]      ram_wr_data_q, ram_wr_data_d;
  logic [1:0]         rd_valid_q, rd_valid_d;
  logic [1:0][DW-1:0] rd_data_q, rd_data_d;
  logic [2:0]         err_q, err_d;

  // Arbitration inputs. A buffered write masks its own port's read, which
  // makes the write go first.
  logic [1:0] req;
  logic       sel;
  logic       gp;

  always_comb begin
    req = wbuf_valid_q | (rd_en_v & ~wbuf_valid_q);
    // On a tie, pick the port that was not granted last. Otherwise pick
    // whichever port is requesting.
    if (req == 2'b11) sel = ~last_q;
    else              sel = req[1];
    gp = gnt_q[1];
  end

  always_comb begin
    state_d       = state_q;
    wbuf_valid_d  = wbuf_valid_q;
    wbuf_addr_d   = wbuf_addr_q;
    wbuf_data_d   = wbuf_data_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    ram_rd_en_d   = ram_rd_en_q;
    ram_rd_addr_d = ram_rd_addr_q;
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    rd_valid_d    = 2'b00;
    rd_data_d     = rd_data_q;
    err_d         = err_q;

    // Posted-write buffers. A buffer that clears on this edge counts as empty,
    // so a strobe coinciding with the end of WRITE is still captured.
    for (int p = 0; p < 2; p++) begin
      if (wr_en_v[p]) begin
        if (!wbuf_valid_q[p] || (state_q == S_WRITE && gnt_q[p])) begin
          wbuf_valid_d[p] = 1'b1;
          wbuf_addr_d[p]  = wr_addr_v[p];
          wbuf_data_d[p]  = wr_data_v[p];
        end else begin
          err_d[p] = 1'b1;
        end
      end else if (state_q == S_WRITE && gnt_q[p]) begin
        wbuf_valid_d[p] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d  = sel ? 2'b10 : 2'b01;
          last_d = sel;
          if (wbuf_valid_q[sel]) begin
            state_d       = S_WRITE;
            ram_wr_en_d   = 1'b1;
            ram_wr_addr_d = wbuf_addr_q[sel];
            ram_wr_data_d = wbuf_data_q[sel];
          end else begin
            state_d       = S_READ;
            ram_rd_en_d   = 1'b1;
            ram_rd_addr_d = rd_addr_v[sel];
            cnt_d         = 8'd0;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
      S_READ: begin
        if (ram_rd_valid) begin
          state_d        = S_DONE;
          ram_rd_en_d    = 1'b0;
          rd_valid_d[gp] = 1'b1;
          rd_data_d[gp]  = ram_rd_data;
        end else if (({1'b0, cnt_q} + 9'd1) == TO_LIM) begin
          // This is the RD_TIMEOUT-th READ cycle without a response.
          state_d        = S_DONE;
          ram_rd_en_d    = 1'b0;
          rd_valid_d[gp] = 1'b1;
          rd_data_d[gp]  = '0;
          err_d[2]       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wbuf_valid_q  <= 2'b00;
      wbuf_addr_q   <= '0;
      wbuf_data_q   <= '0;
      gnt_q         <= 2'b00;
      last_q        <= 1'b1;
      cnt_q         <= 8'd0;
      ram_rd_en_q   <= 1'b0;
      ram_rd_addr_q <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      rd_valid_q    <= 2'b00;
      rd_data_q     <= '0;
      err_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      wbuf_valid_q  <= wbuf_valid_d;
      wbuf_addr_q   <= wbuf_addr_d;
      wbuf_data_q   <= wbuf_data_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      ram_rd_en_q   <= ram_rd_en_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      err_q         <= err_d;
    end
  end

  assign m0_rd_valid = rd_valid_q[0];
  assign m1_rd_valid = rd_valid_q[1];
  assign m0_rd_data  = rd_data_q[0];
  assign m1_rd_data  = rd_data_q[1];
  assign m0_wr_busy  = wbuf_valid_q[0];
  assign m1_wr_busy  = wbuf_valid_q[1];
  assign ram_rd_en   = ram_rd_en_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign grant       = gnt_q;
  assign err         = err_q;

endmodule
